saturn_debug_trace: RTL and testbench

SATURN_DEBUG_TRACE -- requirements
Module: saturn_debug_trace

---
 rtl/saturn_debug_trace.sv | 127 ++++++++++++
 tb/tb_saturn_debug_trace.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/saturn_debug_trace.sv
// rtl/saturn_debug_trace.sv - debug trace capture FIFO with nibble serializer (optional drop counter: SATURN_DEBUG_TRACE_DROP_CNT_EN)
module saturn_debug_trace #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cycle_ctr,
  input  logic        i_debug_cycle,
  input  logic [4:0]  i_alu_reg_dest,
  input  logic [4:0]  i_alu_reg_src_1,
  input  logic [4:0]  i_alu_reg_src_2,
  input  logic [3:0]  i_alu_imm_value,
  input  logic [4:0]  i_alu_opcode,
  input  logic [3:0]  i_instr_type,
  output logic [3:0]  o_nib,
  output logic        o_nib_valid,
  input  logic        i_nib_ready,
  output logic        o_nib_last,
  output logic [4:0]  o_fifo_count,
  output logic        o_overflow,
  output logic [15:0] o_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          dbg_q;
  logic [0:0]    state;
  logic [63:0]   sr;
  logic [3:0]    idx;

  logic          capture;
  logic          full;
  logic          accept;
  logic          pop;
  logic          push;
  logic          drop;
  logic [63:0]   record;

  assign record  = {i_cycle_ctr, i_instr_type, i_alu_imm_value, i_alu_opcode,
                    i_alu_reg_dest, i_alu_reg_src_1, i_alu_reg_src_2, 4'hA};
  assign capture = i_debug_cycle && !dbg_q && !i_reset;
  assign full    = (count == 5'(DEPTH));
  assign accept  = (state == ST_SHIFT) && i_nib_ready;
  // Load the serializer from idle, or chain straight into the next record on the final nibble
  assign pop     = (count != 5'd0) &&
                   ((state == ST_IDLE) || (accept && idx == 4'd15));
  // A full FIFO still takes the record when the head leaves in the same cycle
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign o_nib        = sr[3:0];
  assign o_nib_valid  = (state == ST_SHIFT);
  assign o_nib_last   = (state == ST_SHIFT) && (idx == 4'd15);
  assign o_fifo_count = count;

  // Edge detector on the debug-cycle flag
  always_ff @(posedge i_clk) begin
    if (i_reset) dbg_q <= 1'b0;
    else         dbg_q <= i_debug_cycle;
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Serializer: LSB nibble first, holds while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      sr    <= 64'd0;
      idx   <= 4'd0;
    end else if (pop) begin
      state <= ST_SHIFT;
      sr    <= mem[rd_ptr];
      idx   <= 4'd0;
    end else if (accept) begin
      sr  <= {4'd0, sr[63:4]};
      idx <= idx + 4'd1;
      if (idx == 4'd15) state <= ST_IDLE;
    end
  end

  // Sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_reset)   o_overflow <= 1'b0;
    else if (drop) o_overflow <= 1'b1;
  end

`ifdef SATURN_DEBUG_TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of dropped records
  always_ff @(posedge i_clk) begin
    if (i_reset)                         drop_cnt <= 16'd0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign o_drop_count = drop_cnt;
`else
  assign o_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_saturn_debug_trace.sv
// tb/tb_saturn_debug_trace.sv - scoreboard bench for saturn_debug_trace
module tb_saturn_debug_trace;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_cycle_ctr = 32'd0;
  logic        i_debug_cycle = 1'b0;
  logic [4:0]  i_alu_reg_dest = 5'd0;
  logic [4:0]  i_alu_reg_src_1 = 5'd0;
  logic [4:0]  i_alu_reg_src_2 = 5'd0;
  logic [3:0]  i_alu_imm_value = 4'd0;
  logic [4:0]  i_alu_opcode = 5'd0;
  logic [3:0]  i_instr_type = 4'd0;
  logic [3:0]  o_nib;
  logic        o_nib_valid;
  logic        i_nib_ready = 1'b0;
  logic        o_nib_last;
  logic [4:0]  o_fifo_count;
  logic        o_overflow;
  logic [15:0] o_drop_count;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [4:0] sb[$];

  saturn_debug_trace #(.DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cycle_ctr(i_cycle_ctr),
    .i_debug_cycle(i_debug_cycle), .i_alu_reg_dest(i_alu_reg_dest),
    .i_alu_reg_src_1(i_alu_reg_src_1), .i_alu_reg_src_2(i_alu_reg_src_2),
    .i_alu_imm_value(i_alu_imm_value), .i_alu_opcode(i_alu_opcode),
    .i_instr_type(i_instr_type), .o_nib(o_nib), .o_nib_valid(o_nib_valid),
    .i_nib_ready(i_nib_ready), .o_nib_last(o_nib_last),
    .o_fifo_count(o_fifo_count), .o_overflow(o_overflow),
    .o_drop_count(o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue the 16 expected nibbles of one record, LSB first
  task automatic expect_record(input logic [63:0] rec);
    logic [63:0] r;
    r = rec;
    for (int i = 0; i < 16; i++) begin
      sb.push_back({(i == 15) ? 1'b1 : 1'b0, r[3:0]});
      r = r >> 4;
    end
  endtask

  // One-cycle debug pulse carrying the given decode fields
  task automatic capture(input logic [31:0] cyc, input logic [3:0] typ, input logic [3:0] imm,
                         input logic [4:0] op, input logic [4:0] dst, input logic [4:0] s1,
                         input logic [4:0] s2);
    @(posedge i_clk); #1;
    i_cycle_ctr = cyc; i_instr_type = typ; i_alu_imm_value = imm; i_alu_opcode = op;
    i_alu_reg_dest = dst; i_alu_reg_src_1 = s1; i_alu_reg_src_2 = s2;
    i_debug_cycle = 1'b1;
    @(posedge i_clk); #1;
    i_debug_cycle = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_nib_valid) && n < 2000) begin
      @(posedge i_clk); n++;
    end
    @(negedge i_clk);
    chk({name, "_drained"}, {31'd0, (sb.size() == 0 && !o_nib_valid)}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!o_nib_valid && n < 50) begin
      @(negedge i_clk); n++;
    end
    chk({name, "_valid_seen"}, {31'd0, o_nib_valid}, 32'd1);
  endtask

  // Monitor: compare presented nibble with scoreboard head, pop on acceptance
  always @(negedge i_clk) begin
    if (!i_reset && o_nib_valid) begin
      if (sb.size() == 0) begin
        chk("extra_nibble", {28'd0, o_nib}, 32'hFFFFFFFF);
      end else begin
        chk("nib", {28'd0, o_nib}, {28'd0, sb[0][3:0]});
        chk("last", {31'd0, o_nib_last}, {31'd0, sb[0][4]});
        if (i_nib_ready) begin
          void'(sb.pop_front());
          accepted++;
        end
      end
    end
  end

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", {31'd0, o_nib_valid}, 32'd0);
    chk("rst_last", {31'd0, o_nib_last}, 32'd0);
    chk("rst_nib", {28'd0, o_nib}, 32'd0);
    chk("rst_count", {27'd0, o_fifo_count}, 32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("rst_drop", {16'd0, o_drop_count}, 32'd0);

    // Single capture, hand-assembled record, with latency check
    i_nib_ready = 1'b1;
    expect_record(64'h12345678_2988CA7A);
    capture(32'h12345678, 4'd2, 4'd9, 5'h11, 5'd3, 5'd5, 5'd7);
    chk("latency_not_yet", {31'd0, o_nib_valid}, 32'd0);
    @(posedge i_clk); #1;
    chk("latency_first_valid", {31'd0, o_nib_valid}, 32'd1);
    chk("first_nib_marker", {28'd0, o_nib}, 32'hA);
    drain("single");

    // Backpressure 1,0,0,1 pattern on the same record
    i_nib_ready = 1'b0;
    expect_record(64'h12345678_2988CA7A);
    capture(32'h12345678, 4'd2, 4'd9, 5'h11, 5'd3, 5'd5, 5'd7);
    for (int k = 0; k < 400 && (sb.size() != 0 || o_nib_valid); k++) begin
      @(posedge i_clk); #1;
      i_nib_ready = pat[k % 4];
    end
    i_nib_ready = 1'b1;
    drain("backpressure");

    // Back-to-back: two queued records stream without bubble
    i_nib_ready = 1'b0;
    expect_record({32'hCAFEF00D, 4'h5, 4'h3, 5'h1F, 5'd31, 5'd0, 5'd16, 4'hA});
    expect_record({32'h0000BEEF, 4'hF, 4'hC, 5'h02, 5'd1, 5'd30, 5'd9, 4'hA});
    capture(32'hCAFEF00D, 4'h5, 4'h3, 5'h1F, 5'd31, 5'd0, 5'd16);
    capture(32'h0000BEEF, 4'hF, 4'hC, 5'h02, 5'd1, 5'd30, 5'd9);
    wait_valid("b2b");
    @(posedge i_clk); #1;
    i_nib_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge i_clk);
      chk("b2b_no_bubble", {31'd0, o_nib_valid}, 32'd1);
    end
    drain("b2b");

    // Overflow: six captures into DEPTH=4 with the consumer stalled
    i_nib_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) expect_record({32'h100 + 32'(k), 28'd0, 4'hA});
      capture(32'h100 + 32'(k), 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    end
    @(negedge i_clk);
    chk("ovf_count", {27'd0, o_fifo_count}, 32'd4);
    chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
`ifdef SATURN_DEBUG_TRACE_DROP_CNT_EN
    chk("ovf_drop", {16'd0, o_drop_count}, 32'd1);
`else
    chk("ovf_drop", {16'd0, o_drop_count}, 32'd0);
`endif
    @(posedge i_clk); #1;
    i_nib_ready = 1'b1;
    drain("ovf");
    chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);

    // Reset mid-record with a coincident capture edge
    expect_record({32'h77777777, 28'd0, 4'hA});
    capture(32'h77777777, 4'd0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    wait_valid("mid");
    repeat (6) @(posedge i_clk);
    #1;
    i_nib_ready = 1'b0;
    i_reset = 1'b1;
    i_debug_cycle = 1'b1;
    sb.delete();
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_debug_cycle = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_valid", {31'd0, o_nib_valid}, 32'd0);
    chk("mid_rst_count", {27'd0, o_fifo_count}, 32'd0);
    chk("mid_rst_overflow", {31'd0, o_overflow}, 32'd0);
    chk("mid_rst_drop", {16'd0, o_drop_count}, 32'd0);
    repeat (3) @(negedge i_clk);
    chk("rst_capture_discarded", {26'd0, o_nib_valid, o_fifo_count}, 32'd0);
    i_nib_ready = 1'b1;
    expect_record({32'h00C0FFEE, 4'h1, 4'h2, 5'h03, 5'd4, 5'd5, 5'd6, 4'hA});
    capture(32'h00C0FFEE, 4'h1, 4'h2, 5'h03, 5'd4, 5'd5, 5'd6);
    drain("post_reset");

    // Level hold: debug flag high for 16 cycles yields one record
    accepted = 0;
    expect_record({32'h5A5A5A5A, 4'h9, 4'h8, 5'h07, 5'd6, 5'd5, 5'd4, 4'hA});
    @(posedge i_clk); #1;
    i_cycle_ctr = 32'h5A5A5A5A; i_instr_type = 4'h9; i_alu_imm_value = 4'h8;
    i_alu_opcode = 5'h07; i_alu_reg_dest = 5'd6; i_alu_reg_src_1 = 5'd5; i_alu_reg_src_2 = 5'd4;
    i_debug_cycle = 1'b1;
    repeat (16) @(posedge i_clk);
    #1 i_debug_cycle = 1'b0;
    drain("level");
    chk("level_one_record", accepted, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
